// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_ratio_reg.sv
// Ratio bookkeeping for clk_div_prog: validates loads, holds a pending ratio
// and swaps it in when the divider reports a safe point (idle or wrap).
module clk_div_ratio_reg
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  input  logic             apply_ok,
  output logic [DIV_W-1:0] cur_div,
  output logic             div_ack,
  output logic             div_err
);

  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_valid_q, pend_valid_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             load_ok;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    cur_div_d    = cur_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    load_ok      = div_load && (div_in >= DIV_W'(MIN_DIV));
    err_d        = div_load && !load_ok;

    // A load arriving on the apply cycle wins over anything still pending.
    if (apply_ok && load_ok) begin
      cur_div_d    = div_in;
      ack_d        = 1'b1;
      pend_valid_d = 1'b0;
    end else if (apply_ok && pend_valid_q) begin
      cur_div_d    = pend_div_q;
      ack_d        = 1'b1;
      pend_valid_d = 1'b0;
    end else if (load_ok) begin
      pend_div_d   = div_in;
      pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      cur_div_q    <= DIV_W'(DEFAULT_DIV);
      pend_div_q   <= '0;
      pend_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cur_div_q    <= cur_div_d;
      pend_div_q   <= pend_div_d;
      pend_valid_q <= pend_valid_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign cur_div = cur_div_q;
  assign div_ack = ack_q;
  assign div_err = err_q;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with glitch-free ratio changes
// and stop at period boundaries. Optional tick outputs: define CLKDIV_TICK_EN.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_load,
  output logic             div_ack,
  output logic             div_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             running,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick_rise,
  output logic             tick_fall
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             active;
  logic             wrap;

  assign active = (state_q != ST_IDLE);
  assign wrap   = active && (cnt_q == (cur_div - DIV_W'(1)));

  // Ratio may only change while idle or as the counter returns to zero.
  clk_div_ratio_reg #(
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) u_ratio (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .div_in  (div_in),
    .div_load(div_load),
    .apply_ok(!active || wrap),
    .cur_div (cur_div),
    .div_ack (div_ack),
    .div_err (div_err)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (en) state_d = ST_RUN;
      ST_RUN:      if (!en) state_d = ST_STOPPING;
      ST_STOPPING: begin
        if (en)        state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase

    cnt_d     = (!active || wrap) ? '0 : (cnt_q + DIV_W'(1));
    // cnt_d is zero whenever the ratio can change, so the old ratio is safe here.
    clk_out_d = (cnt_d >= (cur_div >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign running = active;
  assign clk_out = clk_out_q;

`ifdef CLKDIV_TICK_EN
  logic tick_rise_q, tick_rise_d;
  logic tick_fall_q, tick_fall_d;

  always_comb begin
    tick_rise_d = clk_out_d && !clk_out_q;
    tick_fall_d = !clk_out_d && clk_out_q;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
    end else begin
      tick_rise_q <= tick_rise_d;
      tick_fall_q <= tick_fall_d;
    end
  end

  assign tick_rise = tick_rise_q;
  assign tick_fall = tick_fall_q;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (DIV_W=8, DEFAULT_DIV=3).
module tb_clk_div_prog;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       div_ack;
  logic       div_err;
  logic [7:0] cur_div;
  logic       running;
  logic       clk_out;
`ifdef CLKDIV_TICK_EN
  logic       tick_rise;
  logic       tick_fall;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(
    .DIV_W      (8),
    .DEFAULT_DIV(3)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .div_in  (div_in),
    .div_load(div_load),
    .div_ack (div_ack),
    .div_err (div_err),
    .cur_div (cur_div),
    .running (running),
    .clk_out (clk_out)
`ifdef CLKDIV_TICK_EN
    ,
    .tick_rise(tick_rise),
    .tick_fall(tick_fall)
`endif
  );

  // Advance one clk_in edge and settle just past it.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_in = '0;
    tick(); tick();
    tests_run++;
    if (clk_out !== 1'b0) begin tests_failed++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
    tests_run++;
    if (cur_div !== 8'd3) begin tests_failed++; $display("FAIL reset_cur_div: got %0d want 3", cur_div); end
    tests_run++;
    if (running !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b want 0", running); end
    tests_run++;
    if (div_ack !== 1'b0 || div_err !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ack_err: got ack=%b err=%b want 0 0", div_ack, div_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_load();
    div_in = 8'd5; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tests_run++;
    if (div_ack !== 1'b1 || cur_div !== 8'd5) begin
      tests_failed++; $display("FAIL idle_load5: got ack=%b cur=%0d want ack=1 cur=5", div_ack, cur_div);
    end
    tick();
    tests_run++;
    if (div_ack !== 1'b0) begin tests_failed++; $display("FAIL idle_ack_pulse: got %b want 0", div_ack); end
    div_in = 8'd3; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tests_run++;
    if (div_ack !== 1'b1 || cur_div !== 8'd3) begin
      tests_failed++; $display("FAIL idle_load3: got ack=%b cur=%0d want ack=1 cur=3", div_ack, cur_div);
    end
    tick();
  endtask

  task automatic test_default_run();
    logic [0:5] exp_clk;
    exp_clk = 6'b110110;
    en = 1'b1;
    tick();
    tests_run++;
    if (running !== 1'b1 || clk_out !== 1'b0) begin
      tests_failed++; $display("FAIL run_start: got running=%b clk=%b want 1 0", running, clk_out);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (clk_out !== exp_clk[i]) begin
        tests_failed++; $display("FAIL div3_clk[%0d]: got %b want %b", i, clk_out, exp_clk[i]);
      end
    end
  endtask

  task automatic test_load_ratio4();
    logic [0:7] exp_clk;
    exp_clk = 8'b01100110;
    div_in = 8'd4; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tests_run++;
    if (div_ack !== 1'b0) begin tests_failed++; $display("FAIL load4_early_ack1: got %b want 0", div_ack); end
    tick();
    tests_run++;
    if (div_ack !== 1'b0) begin tests_failed++; $display("FAIL load4_early_ack2: got %b want 0", div_ack); end
    tick();
    tests_run++;
    if (div_ack !== 1'b1 || cur_div !== 8'd4 || clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL load4_apply: got ack=%b cur=%0d clk=%b want 1 4 0", div_ack, cur_div, clk_out);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      tests_run++;
      if (clk_out !== exp_clk[i] || div_ack !== 1'b0) begin
        tests_failed++;
        $display("FAIL div4_clk[%0d]: got clk=%b ack=%b want clk=%b ack=0", i, clk_out, div_ack, exp_clk[i]);
      end
    end
  endtask

  task automatic test_last_load_wins();
    int ack_cnt = 0;
    int hi_cnt  = 0;
    div_in = 8'd7; div_load = 1'b1;
    tick();
    ack_cnt += int'(div_ack);
    div_in = 8'd10;
    tick();
    ack_cnt += int'(div_ack);
    div_load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      ack_cnt += int'(div_ack);
      if (i >= 2) hi_cnt += int'(clk_out);
    end
    tests_run++;
    if (ack_cnt != 1) begin tests_failed++; $display("FAIL last_load_acks: got %0d want 1", ack_cnt); end
    tests_run++;
    if (cur_div !== 8'd10) begin tests_failed++; $display("FAIL last_load_cur: got %0d want 10", cur_div); end
    tests_run++;
    if (hi_cnt != 5) begin tests_failed++; $display("FAIL div10_high: got %0d want 5", hi_cnt); end
  endtask

  task automatic test_bad_loads();
    int hi_cnt = 0;
    div_in = 8'd1; div_load = 1'b1;
    tick();
    tests_run++;
    if (div_err !== 1'b1 || div_ack !== 1'b0) begin
      tests_failed++; $display("FAIL err_load1: got err=%b ack=%b want 1 0", div_err, div_ack);
    end
    div_in = 8'd0;
    tick();
    div_load = 1'b0;
    tests_run++;
    if (div_err !== 1'b1) begin tests_failed++; $display("FAIL err_load0: got %b want 1", div_err); end
    tick();
    tests_run++;
    if (div_err !== 1'b0 || cur_div !== 8'd10 || clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_after: got err=%b cur=%0d clk=%b want 0 10 0", div_err, cur_div, clk_out);
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      hi_cnt += int'(clk_out);
    end
    tests_run++;
    if (hi_cnt != 5 || cur_div !== 8'd10) begin
      tests_failed++; $display("FAIL err_undisturbed: got high=%0d cur=%0d want 5 10", hi_cnt, cur_div);
    end
  endtask

  task automatic test_stop();
    logic [0:6] exp_clk;
    logic [0:6] exp_run;
    int n = 0;
    div_in = 8'd6; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    while (div_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tests_run++;
    if (div_ack !== 1'b1 || cur_div !== 8'd6) begin
      tests_failed++; $display("FAIL load6_apply: got ack=%b cur=%0d want 1 6 (waited %0d)", div_ack, cur_div, n);
    end
    tick();
    en = 1'b0;
    exp_clk = 7'b0111000;
    exp_run = 7'b1111000;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests_run++;
      if (clk_out !== exp_clk[i] || running !== exp_run[i]) begin
        tests_failed++;
        $display("FAIL stop[%0d]: got clk=%b run=%b want clk=%b run=%b", i, clk_out, running, exp_clk[i], exp_run[i]);
      end
    end
    en = 1'b1;
    tick(); tick();
    en = 1'b0;
    tick();
    tests_run++;
    if (running !== 1'b1) begin tests_failed++; $display("FAIL stopping_running: got %b want 1", running); end
    en = 1'b1;
    exp_clk = 7'b1110001;
    for (int i = 0; i < 7; i++) begin
      tick();
      tests_run++;
      if (clk_out !== exp_clk[i] || running !== 1'b1) begin
        tests_failed++;
        $display("FAIL resume[%0d]: got clk=%b run=%b want clk=%b run=1", i, clk_out, running, exp_clk[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    tests_run++;
    if (clk_out !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_high: got %b want 1", clk_out); end
    rst_n = 1'b0;
    tick();
    tests_run++;
    if (clk_out !== 1'b0 || cur_div !== 8'd3 || running !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got clk=%b cur=%0d run=%b want 0 3 0", clk_out, cur_div, running);
    end
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (running !== 1'b1 || clk_out !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_run: got run=%b clk=%b want 1 0", running, clk_out);
    end
  endtask

  task automatic test_load_at_wrap();
    logic [0:3] exp_clk;
    exp_clk = 4'b1010;
    tick(); tick();
    div_in = 8'd2; div_load = 1'b1;
    tick();
    div_load = 1'b0;
    tests_run++;
    if (div_ack !== 1'b1 || cur_div !== 8'd2 || clk_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_bypass: got ack=%b cur=%0d clk=%b want 1 2 0", div_ack, cur_div, clk_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests_run++;
      if (clk_out !== exp_clk[i]) begin
        tests_failed++; $display("FAIL div2_clk[%0d]: got %b want %b", i, clk_out, exp_clk[i]);
      end
    end
  endtask

`ifdef CLKDIV_TICK_EN
  task automatic test_ticks();
    logic prev;
    int   rises = 0;
    int   tr    = 0;
    int   tf    = 0;
    for (int i = 0; i < 200; i++) begin
      prev = clk_out;
      tick();
      rises += int'(clk_out && !prev);
      tr    += int'(tick_rise);
      tf    += int'(tick_fall);
      tests_run++;
      if (tick_rise !== (clk_out && !prev) || tick_fall !== (!clk_out && prev)) begin
        tests_failed++;
        $display("FAIL tick_align[%0d]: got rise=%b fall=%b clk=%b prev=%b", i, tick_rise, tick_fall, clk_out, prev);
      end
    end
    tests_run++;
    if (tr != rises || rises != 100 || tf != 100) begin
      tests_failed++; $display("FAIL tick_count: got rise=%0d fall=%0d edges=%0d want 100 100 100", tr, tf, rises);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_load();
    test_default_run();
    test_load_ratio4();
    test_last_load_wins();
    test_bad_loads();
    test_stop();
    test_reset_mid();
    test_load_at_wrap();
`ifdef CLKDIV_TICK_EN
    test_ticks();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
